// File: rtl/mem_port_arbiter.sv
// Shares one single-port backing memory between the fetch and data ports.
// Define ARB_RR_EN to alternate winners on simultaneous requests; default is data over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pick_data;
`ifdef ARB_RR_EN
  logic              last_data_q, last_data_d;
`endif

  // Winner selection; only consulted in IDLE.
  always_comb begin
`ifdef ARB_RR_EN
    if (d_req_i && if_req_i) begin
      pick_data = ~last_data_q;
    end else begin
      pick_data = d_req_i;
    end
`else
    pick_data = d_req_i;
`endif
  end

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cnt_inc    = (cnt_q < TIMEOUT_C) ? (cnt_q + CNT_ONE) : cnt_q;
`ifdef ARB_RR_EN
    last_data_d = last_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          m_req_d = 1'b1;
          cnt_d   = '0;
`ifdef ARB_RR_EN
          last_data_d = pick_data;
`endif
          if (pick_data) begin
            state_d   = GNT_D;
            m_we_d    = d_we_i;
            m_addr_d  = d_addr_i;
            m_wdata_d = d_wdata_i;
          end else begin
            state_d   = GNT_I;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr_i;
            m_wdata_d = '0;
          end
        end
      end

      GNT_I, GNT_D: begin
        if (m_ack_i) begin
          m_req_d = 1'b0;
          if (state_q == GNT_I) begin
            state_d    = DONE_I;
            if_ack_d   = 1'b1;
            if_rdata_d = m_rdata_i;
          end else begin
            state_d = DONE_D;
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata_i;
            end
          end
        end else begin
          // Saturating wait count; the transaction keeps waiting after the flag sets.
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            err_d = 1'b1;
          end
        end
      end

      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign if_ack_o   = if_ack_q;
  assign d_ack_o    = d_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign err_o      = err_q;
  assign stall_o    = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

  // Only one port completes at a time, each ack is a single pulse, and memory is idle during it.
  a_ack_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
    !(if_ack_q && d_ack_q));
  a_if_ack_pulse  : assert property (@(posedge clk_i) disable iff (rst_i)
    if_ack_q |=> !if_ack_q);
  a_d_ack_pulse   : assert property (@(posedge clk_i) disable iff (rst_i)
    d_ack_q |=> !d_ack_q);
  a_no_req_in_ack : assert property (@(posedge clk_i) disable iff (rst_i)
    (if_ack_q || d_ack_q) |-> !m_req_q);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port backing memory between the pipeline's instruction-fetch port and its data-access port. It sits between the CPU's fetch and memory stages and the unified memory. It serialises requests through a grant FSM, returns registered read data with a one-cycle acknowledge pulse, and raises a pipeline stall while either requester is waiting. A watchdog flags a memory that never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 255, maximum cycles in a grant state without `m_ack_i` before `err_o` sets; must be ≥1

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- if_req_i  in  1  fetch request; held high with a stable address until `if_ack_o`
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle pulse; fetch complete
- if_rdata_o  out  DATA_W  fetched word; valid while `if_ack_o` is high, held afterwards
- d_req_i  in  1  data request; held high with stable command fields until `d_ack_o`
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_ack_o  out  1  one-cycle pulse; data access complete
- d_rdata_o  out  DATA_W  read data; updated only on reads, held otherwise
- m_req_o  out  1  request to backing memory
- m_we_o  out  1  write enable to memory
- m_addr_o  out  ADDR_W  latched address
- m_wdata_o  out  DATA_W  latched write data
- m_ack_i  in  1  memory completion; may arrive in the same cycle `m_req_o` first rises
- m_rdata_i  in  DATA_W  memory read data, sampled with `m_ack_i`
- stall_o  out  1  combinational: `(if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o)`
- err_o  out  1  sticky timeout flag

## Operation
FSM states:
- **IDLE**
  - If either request is present, choose a winner, latch the winner's addr/we/wdata into the m_* registers, then go to GNT_I or GNT_D.
  - For a fetch, `m_we_o` latches 0 and `m_wdata_o` latches 0.
- **GNT_I / GNT_D**
  - `m_req_o` = 1 and the m_* fields are held.
  - On `m_ack_i`: capture `m_rdata_i` into the winner's rdata register (GNT_D reads only), then go to DONE_I / DONE_D.
- **DONE_I / DONE_D**
  - `m_req_o` = 0; the matching ack output is 1 for this cycle only.
  - Always go to IDLE next.
  - A requester that drops its request at this edge is not re-granted. A request still held high in IDLE is treated as a new request.

Arbitration:
- Fixed priority: data beats fetch, because the data access belongs to the older instruction.
- A request arriving during a grant waits; it is never dropped.
- Requests are sampled only in IDLE. A requester changing its command fields while a grant is outstanding does not affect the latched m_* fields.

Watchdog:
- An 8-bit-or-wider wait counter clears on entry to a grant state and increments each grant cycle without `m_ack_i`.
- When the count reaches TIMEOUT, `err_o` sets and stays set until reset.
- The FSM keeps waiting; it does not abort.

Reset (asynchronous, any state, including mid-grant):
- State → IDLE; `m_req_o`, `m_we_o`, `if_ack_o`, `d_ack_o`, `err_o` → 0.
- `m_addr_o`, `m_wdata_o`, `if_rdata_o`, `d_rdata_o`, wait counter → 0.
- Priority pointer → data.
- `stall_o` follows its inputs.

## Timing
- Minimum turnaround, with memory acking in the first grant cycle:
  - Request seen at edge 0.
  - `m_req_o` high in cycle 1.
  - Ack pulse in cycle 2.
  - Next grant possible at edge 3.
- Each memory wait cycle adds one cycle.
- The ack pulse is exactly one cycle wide. The rdata output is registered and changes only on the edge entering DONE.
- `m_*` outputs are registered; nothing is combinational from `m_ack_i` to the m_* outputs.
- `stall_o` is the only combinational output. It is high during IDLE/GNT cycles for a pending requester and low in that requester's DONE cycle.
- Simultaneous requests in IDLE result in one grant, then the loser waits through the whole grant.

## Configuration
- `ARB_RR_EN` defined:
  - When both requests are present in IDLE, the requester not granted last wins.
  - A one-bit last-grant register updates on every grant; reset value = fetch last, so data wins the first tie.
  - Single requests are granted immediately regardless of the pointer.
- Not defined: fixed data-over-fetch priority, and the last-grant register is absent.

## Test plan
- Reset then fetch:
  - Stimulus: `if_req_i`=1, addr 0x10; memory acks immediately with 0x00A00093.
  - Required: `m_req_o` high in cycle 1; `if_ack_o` high in cycle 2 only; `if_rdata_o`=0x00A00093; `stall_o` low in cycle 2.
- Simultaneous fetch 0x20 and data read 0x100 (memory returns 0x5A5A5A5A):
  - Without `ARB_RR_EN`: data granted first, then fetch; `d_rdata_o`=0x5A5A5A5A, `d_ack_o` two cycles before the fetch's grant starts.
  - With `ARB_RR_EN` and both held for two rounds: grant order D, I, D, I.
- Data write 0x1C ← 0xDEADBEEF with a 3-cycle memory wait:
  - Required: `m_we_o`=1 and fields stable for 4 grant cycles; `d_ack_o` one pulse; `d_rdata_o` unchanged.
- TIMEOUT=4 with `m_ack_i` held low:
  - Required: `err_o` rises after the 4th wait cycle and stays high after a later ack; the transaction still completes.
- Reset mid-grant:
  - Stimulus: assert `rst_i` asynchronously in GNT_D.
  - Required: `m_req_o`, acks and `err_o` drop without waiting for a clock edge; after release with the request still high, a fresh grant starts from IDLE.
